// File: rtl/arbitro_ula_pkg.sv
// Shared definitions for the main-ALU arbiter: widths, opcode codes and FSM states.
package pacote_ula;

  localparam int LARGURA    = 16;
  localparam int LARGURA_OP = 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  function automatic logic escolhe(input logic valido0, input logic valido1,
                                   input logic ultimo);
    logic id;
    if (valido0 && valido1) begin
      id = ~ultimo;
    end else if (valido1) begin
      id = 1'b1;
    end else begin
      id = 1'b0;
    end
    return id;
  endfunction

endpackage

// File: rtl/arbitro_ula.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// operands and results are registered, one operation in flight at a time.
module arbitro_ula
  import pacote_ula::*;
#(
  parameter int LARGURA    = pacote_ula::LARGURA,
  parameter int LARGURA_OP = pacote_ula::LARGURA_OP
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valido,
  output logic                  req0_pronto,
  input  logic [LARGURA-1:0]    req0_entrada1,
  input  logic [LARGURA-1:0]    req0_entrada2,
  input  logic [LARGURA_OP-1:0] req0_op,
  input  logic                  req1_valido,
  output logic                  req1_pronto,
  input  logic [LARGURA-1:0]    req1_entrada1,
  input  logic [LARGURA-1:0]    req1_entrada2,
  input  logic [LARGURA_OP-1:0] req1_op,
  output logic                  resp0_valido,
  output logic [LARGURA-1:0]    resp0_saida,
  output logic                  resp0_zero,
  input  logic                  resp0_aceito,
  output logic                  resp1_valido,
  output logic [LARGURA-1:0]    resp1_saida,
  output logic                  resp1_zero,
  input  logic                  resp1_aceito,
  output logic [LARGURA-1:0]    ula_entrada1,
  output logic [LARGURA-1:0]    ula_entrada2,
  output logic [LARGURA_OP-1:0] ula_sinal,
  input  logic [LARGURA-1:0]    ula_saida,
  input  logic                  ula_zero
);

  estado_t               estado_r, estado_s;
  logic                  ultimo_r;
  logic                  id_r;
  logic [LARGURA-1:0]    op_a_r, op_b_r;
  logic [LARGURA_OP-1:0] op_r;
  logic [LARGURA-1:0]    res_r;
  logic                  zero_r;
  logic                  concede_s;
  logic                  id_conc_s;
  logic                  aceito_s;

  assign aceito_s = id_r ? resp1_aceito : resp0_aceito;

  // Next-state, grant decision and the combinational pronto strobes.
  always_comb begin
    estado_s    = estado_r;
    concede_s   = 1'b0;
    id_conc_s   = 1'b0;
    req0_pronto = 1'b0;
    req1_pronto = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (req0_valido || req1_valido) begin
          concede_s   = 1'b1;
          id_conc_s   = escolhe(req0_valido, req1_valido, ultimo_r);
          req0_pronto = ~id_conc_s;
          req1_pronto = id_conc_s;
          estado_s    = EXECUTA;
        end else begin
          estado_s = OCIOSO;
        end
      end
      EXECUTA: estado_s = RESPONDE;
      RESPONDE: begin
        if (aceito_s) begin
          estado_s = OCIOSO;
        end else begin
          estado_s = RESPONDE;
        end
      end
      default: estado_s = OCIOSO;
    endcase
  end

  // State, round-robin pointer, operand capture on grant and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r <= OCIOSO;
      ultimo_r <= 1'b1;
      id_r     <= 1'b0;
      op_a_r   <= '0;
      op_b_r   <= '0;
      op_r     <= '0;
      res_r    <= '0;
      zero_r   <= 1'b0;
    end else begin
      estado_r <= estado_s;
      if (concede_s) begin
        ultimo_r <= id_conc_s;
        id_r     <= id_conc_s;
        op_a_r   <= id_conc_s ? req1_entrada1 : req0_entrada1;
        op_b_r   <= id_conc_s ? req1_entrada2 : req0_entrada2;
        op_r     <= id_conc_s ? req1_op       : req0_op;
      end
      if (estado_r == EXECUTA) begin
        res_r  <= ula_saida;
        zero_r <= ula_zero;
      end
    end
  end

  assign ula_entrada1 = op_a_r;
  assign ula_entrada2 = op_b_r;
  assign ula_sinal    = op_r;

  // Responses are decoded from registered state; the idle side reads as zero.
  assign resp0_valido = (estado_r == RESPONDE) && !id_r;
  assign resp1_valido = (estado_r == RESPONDE) && id_r;
  assign resp0_saida  = resp0_valido ? res_r : '0;
  assign resp1_saida  = resp1_valido ? res_r : '0;
  assign resp0_zero   = resp0_valido & zero_r;
  assign resp1_zero   = resp1_valido & zero_r;

endmodule

// File: tb/tb_arbitro_ula.sv
// Directed self-checking bench for arbitro_ula with a behavioural ALU attached.
module tb_arbitro_ula;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valido = 1'b0, req1_valido = 1'b0;
  logic        req0_pronto, req1_pronto;
  logic [15:0] req0_entrada1 = 16'd0, req0_entrada2 = 16'd0;
  logic [15:0] req1_entrada1 = 16'd0, req1_entrada2 = 16'd0;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic        resp0_valido, resp1_valido, resp0_zero, resp1_zero;
  logic [15:0] resp0_saida, resp1_saida;
  logic        resp0_aceito = 1'b1, resp1_aceito = 1'b1;
  logic [15:0] ula_entrada1, ula_entrada2, ula_saida;
  logic [2:0]  ula_sinal;
  logic        ula_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  arbitro_ula dut (
    .clock(clock), .reset(reset),
    .req0_valido(req0_valido), .req0_pronto(req0_pronto),
    .req0_entrada1(req0_entrada1), .req0_entrada2(req0_entrada2), .req0_op(req0_op),
    .req1_valido(req1_valido), .req1_pronto(req1_pronto),
    .req1_entrada1(req1_entrada1), .req1_entrada2(req1_entrada2), .req1_op(req1_op),
    .resp0_valido(resp0_valido), .resp0_saida(resp0_saida), .resp0_zero(resp0_zero),
    .resp0_aceito(resp0_aceito),
    .resp1_valido(resp1_valido), .resp1_saida(resp1_saida), .resp1_zero(resp1_zero),
    .resp1_aceito(resp1_aceito),
    .ula_entrada1(ula_entrada1), .ula_entrada2(ula_entrada2), .ula_sinal(ula_sinal),
    .ula_saida(ula_saida), .ula_zero(ula_zero)
  );

  // External ALU; unassigned codes return a XOR b.
  always_comb begin
    ula_saida = 16'd0;
    case (ula_sinal)
      3'b000:  ula_saida = ula_entrada1 & ula_entrada2;
      3'b001:  ula_saida = ula_entrada1 | ula_entrada2;
      3'b010:  ula_saida = ula_entrada1 + ula_entrada2;
      3'b011:  ula_saida = ula_entrada1 - ula_entrada2;
      3'b100:  ula_saida = ($signed(ula_entrada1) < $signed(ula_entrada2)) ? 16'd1 : 16'd0;
      default: ula_saida = ula_entrada1 ^ ula_entrada2;
    endcase
    ula_zero = (ula_saida == 16'd0);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_pronto0", {31'd0, req0_pronto}, 32'd0);
    chk("rst_pronto1", {31'd0, req1_pronto}, 32'd0);
    chk("rst_valido0", {31'd0, resp0_valido}, 32'd0);
    chk("rst_valido1", {31'd0, resp1_valido}, 32'd0);
    chk("rst_sinal", {29'd0, ula_sinal}, 32'd0);
    chk("rst_ent1", {16'd0, ula_entrada1}, 32'd0);

    // req0 ADD 6,31
    step();
    req0_valido = 1'b1; req0_op = 3'b010; req0_entrada1 = 16'd6; req0_entrada2 = 16'd31;
    #1;
    chk("add_pronto0", {31'd0, req0_pronto}, 32'd1);
    chk("add_pronto1", {31'd0, req1_pronto}, 32'd0);
    step();
    req0_valido = 1'b0;
    #1;
    chk("add_sinal", {29'd0, ula_sinal}, 32'd2);
    chk("add_ent2", {16'd0, ula_entrada2}, 32'd31);
    chk("add_pronto_ex", {31'd0, req0_pronto}, 32'd0);
    chk("add_valido_ex", {31'd0, resp0_valido}, 32'd0);
    step();
    chk("add_valido", {31'd0, resp0_valido}, 32'd1);
    chk("add_saida", {16'd0, resp0_saida}, 32'd37);
    chk("add_zero", {31'd0, resp0_zero}, 32'd0);
    chk("add_valido1", {31'd0, resp1_valido}, 32'd0);
    step();
    chk("add_done", {31'd0, resp0_valido}, 32'd0);

    // Tie right after reset: req0 SUB 4,4 and req1 SUB 23,4
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valido = 1'b1; req0_op = 3'b011; req0_entrada1 = 16'd4;  req0_entrada2 = 16'd4;
    req1_valido = 1'b1; req1_op = 3'b011; req1_entrada1 = 16'd23; req1_entrada2 = 16'd4;
    #1;
    chk("tie_pronto0", {31'd0, req0_pronto}, 32'd1);
    chk("tie_pronto1", {31'd0, req1_pronto}, 32'd0);
    step();
    req0_valido = 1'b0;
    #1;
    chk("tie_wait1", {31'd0, req1_pronto}, 32'd0);
    step();
    chk("sub0_saida", {16'd0, resp0_saida}, 32'd0);
    chk("sub0_zero", {31'd0, resp0_zero}, 32'd1);
    chk("sub0_valido1", {31'd0, resp1_valido}, 32'd0);
    step();
    chk("sub1_pronto1", {31'd0, req1_pronto}, 32'd1);
    step();
    req1_valido = 1'b0;
    step();
    chk("sub1_valido", {31'd0, resp1_valido}, 32'd1);
    chk("sub1_saida", {16'd0, resp1_saida}, 32'd19);
    chk("sub1_zero", {31'd0, resp1_zero}, 32'd0);
    chk("sub1_valido0", {31'd0, resp0_valido}, 32'd0);
    chk("sub1_saida0", {16'd0, resp0_saida}, 32'd0);
    step();
    req0_valido = 1'b1; req0_op = 3'b000; req0_entrada1 = 16'd3; req0_entrada2 = 16'd5;
    req1_valido = 1'b1;
    #1;
    chk("tie2_pronto0", {31'd0, req0_pronto}, 32'd1);
    chk("tie2_pronto1", {31'd0, req1_pronto}, 32'd0);
    step();
    req0_valido = 1'b0; req1_valido = 1'b0;
    step();
    chk("tie2_saida", {16'd0, resp0_saida}, 32'd1);
    step();

    // req1 SLT 4,7 then SLT 5,4
    req1_valido = 1'b1; req1_op = 3'b100; req1_entrada1 = 16'd4; req1_entrada2 = 16'd7;
    #1;
    chk("slt1_pronto", {31'd0, req1_pronto}, 32'd1);
    step();
    req1_valido = 1'b0;
    #1;
    chk("slt1_early", {31'd0, resp1_valido}, 32'd0);
    step();
    chk("slt1_valido", {31'd0, resp1_valido}, 32'd1);
    chk("slt1_saida", {16'd0, resp1_saida}, 32'd1);
    chk("slt1_zero", {31'd0, resp1_zero}, 32'd0);
    step();
    req1_valido = 1'b1; req1_entrada1 = 16'd5; req1_entrada2 = 16'd4;
    #1;
    chk("slt2_pronto", {31'd0, req1_pronto}, 32'd1);
    step();
    req1_valido = 1'b0;
    step();
    chk("slt2_valido", {31'd0, resp1_valido}, 32'd1);
    chk("slt2_saida", {16'd0, resp1_saida}, 32'd0);
    chk("slt2_zero", {31'd0, resp1_zero}, 32'd1);
    step();

    // Back-pressure: req0 AND 6,3 held unaccepted while req1 OR 4,11 waits
    resp0_aceito = 1'b0;
    req0_valido = 1'b1; req0_op = 3'b000; req0_entrada1 = 16'd6; req0_entrada2 = 16'd3;
    #1;
    chk("bp_pronto0", {31'd0, req0_pronto}, 32'd1);
    step();
    req0_valido = 1'b0;
    req1_valido = 1'b1; req1_op = 3'b001; req1_entrada1 = 16'd4; req1_entrada2 = 16'd11;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valido0", {31'd0, resp0_valido}, 32'd1);
      chk("bp_saida0", {16'd0, resp0_saida}, 32'd2);
      chk("bp_pronto1", {31'd0, req1_pronto}, 32'd0);
      step();
    end
    resp0_aceito = 1'b1;
    step();
    chk("bp_released", {31'd0, resp0_valido}, 32'd0);
    chk("bp_grant1", {31'd0, req1_pronto}, 32'd1);
    step();
    req1_valido = 1'b0;
    step();
    chk("or_saida", {16'd0, resp1_saida}, 32'd15);
    chk("or_zero", {31'd0, resp1_zero}, 32'd0);
    step();

    // Reset during EXECUTA drops the operation
    req0_valido = 1'b1; req0_op = 3'b010; req0_entrada1 = 16'd1; req0_entrada2 = 16'd1;
    step();
    req0_valido = 1'b0;
    #1;
    chk("mid_ent1", {16'd0, ula_entrada1}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_valido0", {31'd0, resp0_valido}, 32'd0);
    chk("mid_saida0", {16'd0, resp0_saida}, 32'd0);
    chk("mid_ent1_clr", {16'd0, ula_entrada1}, 32'd0);
    chk("mid_sinal_clr", {29'd0, ula_sinal}, 32'd0);
    step();
    chk("mid_no_resp", {31'd0, resp0_valido}, 32'd0);
    req0_valido = 1'b1;
    #1;
    chk("re_pronto0", {31'd0, req0_pronto}, 32'd1);
    step();
    req0_valido = 1'b0;
    step();
    chk("re_saida", {16'd0, resp0_saida}, 32'd2);
    step();

    // Unassigned opcode 111 is forwarded and its ALU result returned
    req0_valido = 1'b1; req0_op = 3'b111; req0_entrada1 = 16'h00F0; req0_entrada2 = 16'h0F0F;
    #1;
    chk("op7_pronto", {31'd0, req0_pronto}, 32'd1);
    step();
    req0_valido = 1'b0;
    #1;
    chk("op7_sinal", {29'd0, ula_sinal}, 32'd7);
    step();
    chk("op7_valido", {31'd0, resp0_valido}, 32'd1);
    chk("op7_saida", {16'd0, resp0_saida}, 32'h0FFF);
    step();
    chk("op7_idle", {31'd0, resp0_valido}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_ula.md
Name: arbitro_ula

Overview:
- Shares the single 16-bit main ALU between two requesters:
  - requester 0: datapath execute stage;
  - requester 1: auxiliary unit, e.g. branch-target/address computation.
- Each requester gets a valid/ready request handshake and a valid/accept response handshake.
- Round-robin arbitration; operands and result are registered, and the ALU is driven from registers.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational and is instantiated outside this block.

Parameters:
- LARGURA, 16, data width of operands and result.
- LARGURA_OP, 3, width of the ALU operation code.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqK_valido  in  1  (K=0,1) request K presents an operation.
- reqK_pronto  out  1  (K=0,1) request K accepted this cycle.
- reqK_entrada1  in  LARGURA  (K=0,1) operand A.
- reqK_entrada2  in  LARGURA  (K=0,1) operand B.
- reqK_op  in  LARGURA_OP  (K=0,1) ALU operation code.
- respK_valido  out  1  (K=0,1) result for requester K is available.
- respK_saida  out  LARGURA  (K=0,1) registered ALU result.
- respK_zero  out  1  (K=0,1) registered ALU zero flag.
- respK_aceito  in  1  (K=0,1) requester K consumes the result.
- ula_entrada1  out  LARGURA  to ALU operand A.
- ula_entrada2  out  LARGURA  to ALU operand B.
- ula_sinal  out  LARGURA_OP  to ALU operation select.
- ula_saida  in  LARGURA  from ALU result.
- ula_zero  in  1  from ALU zero flag.

Behaviour:
- Opcodes (ALU-defined, passed through unchanged): AND=000, OR=001, ADD=010, SUB=011, SLT=100. Codes 101-111 are forwarded unchecked; whatever the ALU returns is reported.
- FSM states: OCIOSO -> EXECUTA -> RESPONDE -> OCIOSO.
- OCIOSO:
  - If any reqK_valido is high, grant exactly one: reqK_pronto=1, combinational, this cycle only.
  - Capture that requester's entrada1/entrada2/op into operand registers, record its id, go to EXECUTA.
  - If no request is valid, stay.
- Arbitration:
  - Round-robin pointer ultimo holds the id of the last granted requester.
  - Both valid: grant the one that is not ultimo. Only one valid: grant it.
  - ultimo updates on each grant.
- EXECUTA (1 cycle):
  - ula_* driven from operand registers.
  - On the clock edge, capture ula_saida/ula_zero into the result registers; go to RESPONDE.
- RESPONDE:
  - respK_valido=1 for the granted id only; respK_saida/respK_zero hold the captured values.
  - Stay until respK_aceito=1 for that id, then clear valido and go to OCIOSO.
  - aceito for the non-granted id is ignored.
- Latency: grant at cycle T, resp_valido high from T+2. With aceito held high, minimum 3 cycles per operation; no overlap.
- reqK_pronto is 0 outside OCIOSO. A requester holds valido and its operands stable until it sees pronto.
- ula_* hold their register values in all states; they change only on a grant.
- resp outputs of the non-granted requester are 0.
- Reset (any state, including mid-operation):
  - State OCIOSO; ultimo=1, so requester 0 wins the first tie.
  - All pronto/valido=0; result and operand registers 0; ula_sinal=000.
  - An in-flight operation is dropped with no response.

Decomposition:
- Shared package pacote_ula holds:
  - opcode constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT;
  - FSM state encoding OCIOSO/EXECUTA/RESPONDE;
  - LARGURA default 16.
- No sub-module needed. The round-robin choice is a few lines; the ALU is instantiated by the parent alongside this block.

Test Plan:
- After reset, only req0: ADD 6,31 -> req0_pronto at T, ula_sinal=010, resp0_valido at T+2 with saida=37, zero=0; resp1_valido stays 0.
- Both valid together right after reset: req0 SUB 4,4 and req1 SUB 23,4 -> req0 granted first (saida=0, zero=1). After accept, req1 granted (saida=19, zero=0). Next tie grants req0.
- req1 SLT 4,7 then SLT 5,4 -> saida=0000000000000001, then 0000000000000000 with zero=1; each valid 2 cycles after its grant.
- resp0_aceito held low 5 cycles after AND 6,3 -> resp0_valido stays high and saida=2 stays stable. req1 OR 4,11 waiting with pronto=0 throughout; granted the cycle after accept, saida=15.
- Reset asserted during EXECUTA of ADD 1,1 -> next cycle all outputs 0, no response issued; a subsequent req0 ADD 1,1 returns 2 normally.
- Opcode 111 from req0 -> forwarded on ula_sinal=111; ALU output returned as-is with normal 2-cycle timing and no hang.
